bist_alu_ctrl: RTL and testbench

BIST controller that sequences the ALU under self-test. It generates pseudo-random operands with an LFSR and steps through every ALU opcode. It compacts each ALU result into a MISR and compares the final signature against a golden value. It sits between the top-level BIST wrapper (start/status) and the combinational ALU datapath, and drives FAULT_DETECTED.

---
 rtl/bist_alu_ctrl.sv | 140 ++++++++++++++
 tb/tb_bist_alu_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_alu_ctrl.sv
// BIST controller for the ALU under self-test.
// An LFSR supplies pseudo-random operands while the opcode steps through
// every ALU function. Each ALU result is folded into a MISR. The final
// signature is compared against a golden value to raise FAULT_DETECTED.
module bist_alu_ctrl #(
    parameter int               WIDTH      = 8,
    parameter int               OPW        = 3,
    parameter int               NUM_OPS    = 8,
    parameter int               PATTERNS   = 64,
    parameter logic [15:0]      LFSR_SEED  = 16'hACE1,
    parameter logic [WIDTH-1:0] GOLDEN_SIG = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] alu_y,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    output logic             busy,
    output logic             done,
    output logic             FAULT_DETECTED,
    output logic [WIDTH-1:0] signature
);

    // The total vector count sets the counter width.
    // The terminal count ends RUN, so the counter never wraps.
    localparam int            N        = NUM_OPS * PATTERNS;
    localparam int            CW       = $clog2(N);
    localparam logic [CW-1:0] LAST     = CW'(N - 1);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0]   SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        RUN   = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_d;
    logic [WIDTH-1:0] misr_q;
    logic [WIDTH-1:0] misr_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [OPW-1:0]   op_d;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [OPW-1:0]   alu_op_q;
    logic             busy_q;
    logic             done_q;
    logic             fault_q;

    // Next-step values for the LFSR, MISR, vector counter and opcode.
    // They are used only while vectors are being applied.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        misr_d = {misr_q[6:0], misr_q[7] ^ misr_q[5] ^ misr_q[4] ^ misr_q[3]} ^ alu_y;
        cnt_d  = cnt_q + CW'(1);
        op_d   = OPW'(32'(cnt_d) / 32'(PATTERNS));
    end

    // Sequencer FSM with all outputs registered.
    // Reset aborts any run on the edge it is sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED_EFF;
            misr_q   <= '0;
            cnt_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= INIT;
                        busy_q  <= 1'b1;
                    end
                end
                INIT: begin
                    lfsr_q   <= SEED_EFF;
                    misr_q   <= '0;
                    cnt_q    <= '0;
                    fault_q  <= 1'b0;
                    alu_a_q  <= SEED_EFF[15:8];
                    alu_b_q  <= SEED_EFF[7:0];
                    alu_op_q <= '0;
                    state_q  <= RUN;
                end
                RUN: begin
                    misr_q <= misr_d;
                    if (cnt_q == LAST) begin
                        state_q <= CHECK;
                    end else begin
                        lfsr_q   <= lfsr_d;
                        alu_a_q  <= lfsr_d[15:8];
                        alu_b_q  <= lfsr_d[7:0];
                        cnt_q    <= cnt_d;
                        alu_op_q <= op_d;
                    end
                end
                CHECK: begin
                    fault_q <= (misr_q != GOLDEN_SIG);
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    if (start) begin
                        state_q <= INIT;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_op         = alu_op_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign FAULT_DETECTED = fault_q;
    assign signature      = misr_q;

endmodule

// File: tb/tb_bist_alu_ctrl.sv
// Self-checking bench for bist_alu_ctrl.
// A behavioural ALU drives alu_y. An optional stuck-at-1 on bit 0 models a faulty ALU.
// A reference model built from the LFSR/MISR rules predicts the operand stream and the signature.
module tb_bist_alu_ctrl;

    // Reference ALU, also used to derive the golden signature at elaboration.
    function automatic logic [7:0] aluRef(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~(a & b);
            3'd6:    return {a[6:0], 1'b0};
            default: return {1'b0, a[7:1]};
        endcase
    endfunction

    // Fault-free signature after 8 opcodes x 64 patterns from seed ACE1.
    function automatic logic [7:0] computeGolden();
        logic [15:0] l;
        logic [7:0]  m;
        l = 16'hACE1;
        m = 8'h00;
        for (int op = 0; op < 8; op++) begin
            for (int p = 0; p < 64; p++) begin
                m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ aluRef(l[15:8], l[7:0], 3'(op));
                l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            end
        end
        return m;
    endfunction

    localparam logic [7:0] GOLDEN = computeGolden();
    localparam int         NVEC   = 512;
    localparam int         TDONE  = 514;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] aluY;
    logic [7:0] aluA;
    logic [7:0] aluB;
    logic [2:0] aluOp;
    logic       busy;
    logic       done;
    logic       faultDetected;
    logic [7:0] signature;
    bit         stuckBit0;

    int numCompared;
    int numMismatched;

    logic [7:0] expA  [NVEC];
    logic [7:0] expB  [NVEC];
    logic [2:0] expOp [NVEC];
    logic [7:0] expSig;

    typedef struct {
        int         offset;
        logic       expBusy;
        logic       expDone;
        bit         chkAB;
        logic [7:0] expA;
        logic [7:0] expB;
        bit         chkOp;
        logic [2:0] expOp;
        bit         chkSigFault;
        logic [7:0] expSig;
        logic       expFault;
    } vec_t;

    vec_t vecTable [9];

    bist_alu_ctrl #(
        .WIDTH      (8),
        .OPW        (3),
        .NUM_OPS    (8),
        .PATTERNS   (64),
        .LFSR_SEED  (16'hACE1),
        .GOLDEN_SIG (GOLDEN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .alu_y          (aluY),
        .alu_a          (aluA),
        .alu_b          (aluB),
        .alu_op         (aluOp),
        .busy           (busy),
        .done           (done),
        .FAULT_DETECTED (faultDetected),
        .signature      (signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU under test, with an optional stuck-at-1 on bit 0.
    always_comb aluY = aluRef(aluA, aluB, aluOp) | {7'b0, stuckBit0};

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s[%0d] actual=0x%0h expected=0x%0h", name, idx, actual, expected);
        end
    endtask

    // Predict the whole operand stream and the final signature for one run.
    task automatic buildModel(input bit stuck);
        logic [15:0] l;
        logic [7:0]  m;
        logic [7:0]  y;
        l = 16'hACE1;
        m = 8'h00;
        for (int i = 0; i < NVEC; i++) begin
            expA[i]  = l[15:8];
            expB[i]  = l[7:0];
            expOp[i] = 3'(i / 64);
            y        = aluRef(expA[i], expB[i], expOp[i]) | {7'b0, stuck};
            m        = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ y;
            l        = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        expSig = m;
    endtask

    // One-cycle start pulse. Returns at the negedge just after the start edge.
    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_busy"}, 0, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 0, 32'(done), 32'd0);
        checkOutput({tag, "_fault"}, 0, 32'(faultDetected), 32'd0);
        checkOutput({tag, "_sig"}, 0, 32'(signature), 32'd0);
        checkOutput({tag, "_ops"}, 0, {13'd0, aluA, aluB, aluOp}, 32'd0);
    endtask

    // Full run: optional table checks, random spurious starts, per-cycle operand check.
    task automatic runTest(input bit stuck, input bit useTable, input bit noisy);
        int doneAt;
        stuckBit0 = stuck;
        buildModel(stuck);
        applyStimulus();
        doneAt = -1;
        for (int o = 0; o <= 600; o++) begin
            if (useTable) begin
                for (int t = 0; t < 9; t++) begin
                    if (vecTable[t].offset == o) begin
                        checkOutput("tblBusy", o, 32'(busy), 32'(vecTable[t].expBusy));
                        checkOutput("tblDone", o, 32'(done), 32'(vecTable[t].expDone));
                        if (vecTable[t].chkAB) begin
                            checkOutput("tblA", o, 32'(aluA), 32'(vecTable[t].expA));
                            checkOutput("tblB", o, 32'(aluB), 32'(vecTable[t].expB));
                        end
                        if (vecTable[t].chkOp)
                            checkOutput("tblOp", o, 32'(aluOp), 32'(vecTable[t].expOp));
                        if (vecTable[t].chkSigFault) begin
                            checkOutput("tblSig", o, 32'(signature), 32'(vecTable[t].expSig));
                            checkOutput("tblFault", o, 32'(faultDetected), 32'(vecTable[t].expFault));
                        end
                    end
                end
            end
            if (o >= 1 && o <= NVEC) begin
                checkOutput("runVec", o, {13'd0, aluA, aluB, aluOp},
                            {13'd0, expA[o-1], expB[o-1], expOp[o-1]});
                checkOutput("runBusy", o, 32'(busy), 32'd1);
            end
            if (done) begin
                doneAt = o;
                break;
            end
            start = (noisy && o >= 5 && o <= 500) ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("doneCycle", 0, 32'(doneAt), 32'(TDONE));
        checkOutput("finalSig", 0, 32'(signature), 32'(expSig));
        checkOutput("finalFault", 0, 32'(faultDetected), 32'(expSig != GOLDEN));
        // DONE without start holds every output.
        for (int h = 0; h < 4; h++) begin
            @(negedge clk);
            checkOutput("holdDone", h, {30'd0, done, busy}, 32'd2);
            checkOutput("holdSig", h, 32'(signature), 32'(expSig));
            checkOutput("holdFault", h, 32'(faultDetected), 32'(expSig != GOLDEN));
            checkOutput("holdOps", h, {13'd0, aluA, aluB, aluOp},
                        {13'd0, expA[NVEC-1], expB[NVEC-1], expOp[NVEC-1]});
        end
    endtask

    initial begin
        numCompared   = 0;
        numMismatched = 0;
        stuckBit0     = 1'b0;
        vecTable[0] = '{0,   1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        vecTable[1] = '{1,   1'b1, 1'b0, 1'b1, 8'hAC, 8'hE1, 1'b1, 3'd0, 1'b1, 8'h00, 1'b0};
        vecTable[2] = '{2,   1'b1, 1'b0, 1'b1, 8'h59, 8'hC3, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0};
        vecTable[3] = '{64,  1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0};
        vecTable[4] = '{65,  1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'd1, 1'b0, 8'h00, 1'b0};
        vecTable[5] = '{129, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'd2, 1'b0, 8'h00, 1'b0};
        vecTable[6] = '{512, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'd7, 1'b0, 8'h00, 1'b0};
        vecTable[7] = '{513, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        vecTable[8] = '{514, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};

        // Reset held three cycles with start high.
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checkIdleZero("reset");
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkIdleZero("idle");

        // Fault-free run ends matching the golden signature.
        $display("[TB] fault-free run");
        runTest(1'b0, 1'b1, 1'b0);
        checkOutput("goldenMatch", 0, 32'(signature), 32'(GOLDEN));

        // Start pulses during RUN leave the timing unchanged.
        $display("[TB] run with spurious start pulses");
        runTest(1'b0, 1'b1, 1'b1);

        // Stuck-at-1 ALU bit 0 must be detected.
        $display("[TB] faulty ALU run");
        runTest(1'b1, 1'b0, 1'b0);
        checkOutput("faultSigDiffers", 0, 32'(signature != GOLDEN), 32'd1);

        // Restart from the failing DONE with the fault removed.
        $display("[TB] restart after failing run");
        runTest(1'b0, 1'b1, 1'b0);

        // Abort at RUN cycle 100, then a fresh full run.
        $display("[TB] abort mid-run");
        applyStimulus();
        repeat (100) @(negedge clk);
        checkOutput("preAbortBusy", 100, 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkIdleZero("abort");
        reset = 1'b0;
        @(negedge clk);
        checkIdleZero("postAbort");
        runTest(1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
